// File: rtl/ysyx_22050598_defines.sv
// Shared FIFO helpers: pointer/count widths and the legal depth range.
package ysyx_22050598_defines;

    localparam int DP_MIN = 1;
    localparam int DP_MAX = 64;

    // A single-entry FIFO still needs a 1-bit index so the port is never zero-width.
    function automatic int ptr_w(input int dp);
        return (dp <= 1) ? 1 : $clog2(dp);
    endfunction

    function automatic int cnt_w(input int dp);
        return $clog2(dp + 1);
    endfunction

    function automatic bit dp_legal(input int dp);
        return (dp >= DP_MIN) && (dp <= DP_MAX);
    endfunction

endpackage

// File: rtl/ysyx_22050598_fifo_ptr.sv
// FIFO pointer: index that wraps explicitly at DP-1, plus a wrap bit toggled on each wrap.
module ysyx_22050598_fifo_ptr
    import ysyx_22050598_defines::*;
#(
    parameter int DP = 4,
    localparam int PW = ptr_w(DP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    output logic [PW-1:0] idx_o,
    output logic          wrap_o
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DP - 1);

    logic [PW-1:0] idx_q, idx_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        // NOTE: defaults first so every path assigns idx_d/wrap_d; no latch can form.
        idx_d  = idx_q;
        wrap_d = wrap_q;
        if (inc_i) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                wrap_d = ~wrap_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/ysyx_22050598_sirv_gnrl_fifo.sv
// General valid/ready FIFO with wrap-bit full/empty detection and optional ready cut.
module ysyx_22050598_sirv_gnrl_fifo
    import ysyx_22050598_defines::*;
#(
    parameter int CUT_READY = 1,
    parameter int DP        = 4,
    parameter int DW        = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vld,
    output logic                  i_rdy,
    input  logic [DW-1:0]         i_dat,
    output logic                  o_vld,
    input  logic                  o_rdy,
    output logic [DW-1:0]         o_dat,
    output logic [cnt_w(DP)-1:0]  count
);

    localparam int PW = ptr_w(DP);
    localparam int CW = cnt_w(DP);

    if (!dp_legal(DP)) begin : g_bad_dp
        $error("ysyx_22050598_sirv_gnrl_fifo: DP=%0d outside %0d..%0d", DP, DP_MIN, DP_MAX);
    end

    logic [PW-1:0] wr_idx, rd_idx;
    logic          wr_wrap, rd_wrap;
    logic          wr_en, rd_en, full, empty;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DP];

    assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);

    assign o_vld = ~empty;
    // With the cut disabled a full FIFO may still accept when the slot is freed this cycle.
    assign i_rdy = (CUT_READY == 0) ? (~full | o_rdy) : ~full;

    assign wr_en = i_vld & i_rdy;
    assign rd_en = o_vld & o_rdy;

    ysyx_22050598_fifo_ptr #(.DP(DP)) u_wr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (wr_en),
        .idx_o  (wr_idx),
        .wrap_o (wr_wrap)
    );

    ysyx_22050598_fifo_ptr #(.DP(DP)) u_rd_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (rd_en),
        .idx_o  (rd_idx),
        .wrap_o (rd_wrap)
    );

    for (genvar g = 0; g < DP; g++) begin : g_entry
        // NOTE: storage is not reset; o_vld=0 masks whatever stale data it holds.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_idx == PW'(g))) begin
                mem_q[g] <= i_dat;
            end
        end
    end

    assign o_dat = mem_q[rd_idx];

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_ysyx_22050598_sirv_gnrl_fifo.sv
// Bench for the general FIFO: four configurations checked against per-instance queue models.
module tb_ysyx_22050598_sirv_gnrl_fifo;

    localparam int NI = 4;
    // Instance configurations: 0: DP4/cut, 1: DP4/pass, 2: DP3/cut, 3: DP1/pass.
    int dp_of [NI] = '{4, 4, 3, 1};
    bit cr_of [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk;
    logic        rst_n;
    logic        vld  [NI];
    logic        rdy  [NI];
    logic [63:0] dat  [NI];
    logic        ird  [NI];
    logic        ovl  [NI];
    logic [63:0] odat [NI];
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [0:0]  cnt3;

    typedef logic [63:0] q_t [$];
    q_t mq [NI];

    int          checks   = 0;
    int          failures = 0;
    logic        e_rdy, e_vld;
    logic [63:0] e_dat;
    int          e_cnt;

    ysyx_22050598_sirv_gnrl_fifo #(.CUT_READY(1), .DP(4), .DW(64)) u_a (
        .clk(clk), .rst_n(rst_n), .i_vld(vld[0]), .i_rdy(ird[0]), .i_dat(dat[0]),
        .o_vld(ovl[0]), .o_rdy(rdy[0]), .o_dat(odat[0]), .count(cnt0));
    ysyx_22050598_sirv_gnrl_fifo #(.CUT_READY(0), .DP(4), .DW(64)) u_b (
        .clk(clk), .rst_n(rst_n), .i_vld(vld[1]), .i_rdy(ird[1]), .i_dat(dat[1]),
        .o_vld(ovl[1]), .o_rdy(rdy[1]), .o_dat(odat[1]), .count(cnt1));
    ysyx_22050598_sirv_gnrl_fifo #(.CUT_READY(1), .DP(3), .DW(64)) u_c (
        .clk(clk), .rst_n(rst_n), .i_vld(vld[2]), .i_rdy(ird[2]), .i_dat(dat[2]),
        .o_vld(ovl[2]), .o_rdy(rdy[2]), .o_dat(odat[2]), .count(cnt2));
    ysyx_22050598_sirv_gnrl_fifo #(.CUT_READY(0), .DP(1), .DW(64)) u_d (
        .clk(clk), .rst_n(rst_n), .i_vld(vld[3]), .i_rdy(ird[3]), .i_dat(dat[3]),
        .o_vld(ovl[3]), .o_rdy(rdy[3]), .o_dat(odat[3]), .count(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] act_cnt(input int k);
        case (k)
            0:       return {4'b0, cnt0};
            1:       return {4'b0, cnt1};
            2:       return {5'b0, cnt2};
            default: return {6'b0, cnt3};
        endcase
    endfunction

    // Drive one instance's inputs, move to the falling edge and form expectations from the model.
    task automatic pre(input int k, input bit v, input bit r, input logic [63:0] d);
        vld[k] = v;
        rdy[k] = r;
        dat[k] = d;
        @(negedge clk);
        e_cnt = mq[k].size();
        e_vld = (e_cnt != 0);
        e_rdy = (e_cnt != dp_of[k]) || (!cr_of[k] && r);
        e_dat = e_vld ? mq[k][0] : 64'h0;
    endtask

    // Take the rising edge and apply the handshakes the model predicted.
    task automatic post(input int k);
        @(posedge clk);
        if (e_vld && rdy[k]) void'(mq[k].pop_front());
        if (vld[k] && e_rdy) mq[k].push_back(dat[k]);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b0;
            rdy[k] = 1'b0;
            dat[k] = 64'h0;
        end
        #3;
        for (int k = 0; k < NI; k++) begin
            checks += 3;
            if (ird[k] !== 1'b1) begin failures++; $display("FAIL reset_i_rdy inst=%0d got=%0b exp=1", k, ird[k]); end
            if (ovl[k] !== 1'b0) begin failures++; $display("FAIL reset_o_vld inst=%0d got=%0b exp=0", k, ovl[k]); end
            if (act_cnt(k) !== 7'd0) begin failures++; $display("FAIL reset_count inst=%0d got=%0d exp=0", k, act_cnt(k)); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            pre(0, 1'b0, 1'b0, 64'h0);
            post(0);
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks += 3;
            if (ird[k] !== 1'b1) begin failures++; $display("FAIL idle_i_rdy inst=%0d got=%0b exp=1", k, ird[k]); end
            if (ovl[k] !== 1'b0) begin failures++; $display("FAIL idle_o_vld inst=%0d got=%0b exp=0", k, ovl[k]); end
            if (act_cnt(k) !== 7'd0) begin failures++; $display("FAIL idle_count inst=%0d got=%0d exp=0", k, act_cnt(k)); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp_seq [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
        for (int i = 0; i < 4; i++) begin
            pre(0, 1'b1, 1'b0, exp_seq[i]);
            checks++;
            if (ird[0] !== 1'b1) begin failures++; $display("FAIL fill_i_rdy step=%0d got=%0b exp=1", i, ird[0]); end
            post(0);
        end
        pre(0, 1'b0, 1'b0, 64'h0);
        checks += 2;
        if (act_cnt(0) !== 7'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", act_cnt(0)); end
        if (ird[0] !== 1'b0) begin failures++; $display("FAIL full_i_rdy got=%0b exp=0", ird[0]); end
        post(0);
        for (int i = 0; i < 4; i++) begin
            pre(0, 1'b0, 1'b1, 64'h0);
            checks += 2;
            if (ovl[0] !== 1'b1) begin failures++; $display("FAIL drain_o_vld step=%0d got=%0b exp=1", i, ovl[0]); end
            if (odat[0] !== exp_seq[i]) begin failures++; $display("FAIL drain_o_dat step=%0d got=%0h exp=%0h", i, odat[0], exp_seq[i]); end
            post(0);
        end
        pre(0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (ovl[0] !== 1'b0) begin failures++; $display("FAIL drained_o_vld got=%0b exp=0", ovl[0]); end
        post(0);
    endtask

    task automatic test_full_pass();
        for (int i = 1; i <= 4; i++) begin
            pre(1, 1'b1, 1'b0, 64'(i * 'h11));
            post(1);
        end
        pre(1, 1'b1, 1'b1, 64'h55);
        checks += 3;
        if (ird[1] !== 1'b1) begin failures++; $display("FAIL pass_i_rdy got=%0b exp=1", ird[1]); end
        if (odat[1] !== 64'h11) begin failures++; $display("FAIL pass_o_dat got=%0h exp=11", odat[1]); end
        if (act_cnt(1) !== 7'd4) begin failures++; $display("FAIL pass_pre_count got=%0d exp=4", act_cnt(1)); end
        post(1);
        pre(1, 1'b0, 1'b0, 64'h0);
        checks++;
        if (act_cnt(1) !== 7'd4) begin failures++; $display("FAIL pass_post_count got=%0d exp=4", act_cnt(1)); end
        post(1);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] want;
            want = (i == 3) ? 64'h55 : 64'((i + 2) * 'h11);
            pre(1, 1'b0, 1'b1, 64'h0);
            checks++;
            if (odat[1] !== want) begin failures++; $display("FAIL pass_drain step=%0d got=%0h exp=%0h", i, odat[1], want); end
            post(1);
        end
    endtask

    task automatic test_wrap_dp3();
        int nxt = 0;
        for (int i = 0; i < 11; i++) begin
            bit wv;
            wv = (i < 10);
            pre(2, wv, 1'b1, 64'(i));
            checks += 2;
            if (act_cnt(2) > 7'd3) begin failures++; $display("FAIL wrap_count cyc=%0d got=%0d exp<=3", i, act_cnt(2)); end
            if (wv && ird[2] !== 1'b1) begin failures++; $display("FAIL wrap_i_rdy cyc=%0d got=%0b exp=1", i, ird[2]); end
            if (ovl[2] === 1'b1) begin
                checks++;
                if (odat[2] !== 64'(nxt)) begin failures++; $display("FAIL wrap_order cyc=%0d got=%0h exp=%0h", i, odat[2], nxt); end
                nxt++;
            end
            post(2);
        end
        checks += 3;
        if (nxt != 10) begin failures++; $display("FAIL wrap_reads got=%0d exp=10", nxt); end
        if (u_c.u_wr_ptr.idx_o !== 2'(10 % 3)) begin failures++; $display("FAIL wrap_wr_idx got=%0d exp=%0d", u_c.u_wr_ptr.idx_o, 10 % 3); end
        if (u_c.u_wr_ptr.wrap_o !== 1'((10 / 3) % 2)) begin failures++; $display("FAIL wrap_wr_wrap got=%0b exp=%0b", u_c.u_wr_ptr.wrap_o, (10 / 3) % 2); end
    endtask

    task automatic test_reset_mid();
        pre(0, 1'b1, 1'b0, 64'h01);
        post(0);
        pre(0, 1'b1, 1'b0, 64'h02);
        post(0);
        pre(0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (act_cnt(0) !== 7'd2) begin failures++; $display("FAIL mid_hold_count got=%0d exp=2", act_cnt(0)); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (ovl[0] !== 1'b0) begin failures++; $display("FAIL mid_rst_o_vld got=%0b exp=0", ovl[0]); end
        if (act_cnt(0) !== 7'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", act_cnt(0)); end
        if (ird[0] !== 1'b1) begin failures++; $display("FAIL mid_rst_i_rdy got=%0b exp=1", ird[0]); end
        for (int k = 0; k < NI; k++) mq[k].delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        pre(0, 1'b1, 1'b0, 64'hAA);
        post(0);
        pre(0, 1'b0, 1'b0, 64'h0);
        checks += 3;
        if (ovl[0] !== 1'b1) begin failures++; $display("FAIL mid_after_o_vld got=%0b exp=1", ovl[0]); end
        if (odat[0] !== 64'hAA) begin failures++; $display("FAIL mid_after_o_dat got=%0h exp=aa", odat[0]); end
        if (act_cnt(0) !== 7'd1) begin failures++; $display("FAIL mid_after_count got=%0d exp=1", act_cnt(0)); end
        post(0);
        pre(0, 1'b0, 1'b1, 64'h0);
        post(0);
    endtask

    task automatic test_random(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            bit v, r;
            int pv;
            pv = ((i / 300) % 2 == 0) ? 75 : 30;
            v = ($urandom_range(0, 99) < pv);
            r = ($urandom_range(0, 99) < (105 - pv));
            pre(k, v, r, {$urandom, $urandom});
            checks += 3;
            if (ird[k] !== e_rdy) begin failures++; $display("FAIL rand_i_rdy inst=%0d cyc=%0d got=%0b exp=%0b", k, i, ird[k], e_rdy); end
            if (ovl[k] !== e_vld) begin failures++; $display("FAIL rand_o_vld inst=%0d cyc=%0d got=%0b exp=%0b", k, i, ovl[k], e_vld); end
            if (act_cnt(k) !== 7'(e_cnt)) begin failures++; $display("FAIL rand_count inst=%0d cyc=%0d got=%0d exp=%0d", k, i, act_cnt(k), e_cnt); end
            if (e_vld) begin
                checks++;
                if (odat[k] !== e_dat) begin failures++; $display("FAIL rand_o_dat inst=%0d cyc=%0d got=%0h exp=%0h", k, i, odat[k], e_dat); end
            end
            post(k);
        end
        vld[k] = 1'b0;
        rdy[k] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pass();
        test_wrap_dp3();
        test_reset_mid();
        test_random(0, 10000);
        test_random(1, 2000);
        test_random(2, 2000);
        test_random(3, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
